// File: rtl/serial_sub_pkg.sv
// Shared FSM encoding and width helper for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout = borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Start loads operands in IDLE; Done pulses one cycle after the last bit.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               fs_d, fs_b;
  logic [WIDTH-1:0]   d_shift;
  logic               last;

  full_subtractor u_fs (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (br_q),
    .Diff (fs_d),
    .Bout (fs_b)
  );

  assign last = (cnt_q == LAST);

  // Result shift register: the new bit enters at the MSB, so only the
  // upper WIDTH-1 bits of history ever need to be stored.
  generate
    if (WIDTH == 1) begin : g_w1
      assign d_shift = fs_d;
    end else begin : g_wn
      logic [WIDTH-2:0] dh_q;
      always_ff @(posedge Clk) begin
        if (!Rst_n)                dh_q <= '0;
        else if (state_q == SHIFT) dh_q <= d_shift[WIDTH-1:1];
      end
      assign d_shift = {fs_d, dh_q};
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != IDLE);
    Done = (state_q == DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          a_q   <= A;
          b_q   <= B;
          br_q  <= Bin;
          cnt_q <= '0;
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= fs_b;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            diff_q <= d_shift;
            bout_q <= fs_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor and its full_subtractor cell.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Bin = 1'b0;
  logic         Busy, Done, Bout;
  logic [W-1:0] Diff;

  logic fa = 1'b0, fb = 1'b0, fbin = 1'b0, fdiff, fbout;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout)
  );

  full_subtractor u_cell (
    .A(fa), .B(fb), .Bin(fbin), .Diff(fdiff), .Bout(fbout)
  );

  // Reference: plain integer subtraction; borrow is the sign of the result.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return {1'(r < 0), W'(r)};
  endfunction

  // Launches one operation as soon as Busy is low and returns what was seen.
  task automatic run_op(input logic [W-1:0] a, b, input logic bin, input int restart_at,
                        output int done_at, output logic busy1,
                        output logic [W-1:0] diff, output logic bout, output bit stable);
    logic [W-1:0] prev;
    int n;
    done_at = -1; busy1 = 1'b0; diff = 'x; bout = 1'bx; stable = 1'b1; n = 0;
    @(negedge Clk);
    while (Busy && n < 50) begin @(negedge Clk); n++; end
    prev = Diff;
    A = a; B = b; Bin = bin; Start = 1'b1;
    for (int c = 1; c <= 3 * W + 8; c++) begin
      @(negedge Clk);
      Start = (c == restart_at);
      if (c == restart_at) begin A = 1; B = 1; Bin = 0; end
      else begin A = W'($urandom); B = W'($urandom); Bin = 1'($urandom); end
      if (c == 1) busy1 = Busy;
      if (Done) begin done_at = c; diff = Diff; bout = Bout; break; end
      if (Diff !== prev) stable = 1'b0;
    end
    Start = 1'b0;
  endtask

  task automatic test_full_sub();
    for (int i = 0; i < 8; i++) begin
      int r;
      logic ed, eb;
      fa = 1'(i >> 2); fb = 1'(i >> 1); fbin = 1'(i);
      r = int'(fa) - int'(fb) - int'(fbin);
      ed = 1'(r); eb = (r < 0);
      #1;
      checks++;
      if ({fbout, fdiff} !== {eb, ed}) begin
        failures++;
        $display("FAIL cell row %0d: got bout,diff=%b%b exp %b%b", i, fbout, fdiff, eb, ed);
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b1; A = 4'd9; B = 4'd3;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Busy, Done, Diff, Bout} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got busy=%b done=%b diff=%h bout=%b exp all 0", Busy, Done, Diff, Bout);
    end
    Rst_n = 1'b1; Start = 1'b0;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset start dropped: got busy=%b exp 0", Busy);
    end
  endtask

  task automatic test_basic();
    int d_at; logic b1; logic [W-1:0] df; logic bo; bit st;
    run_op(4'd9, 4'd3, 1'b0, 0, d_at, b1, df, bo, st);
    checks++;
    if (b1 !== 1'b1) begin failures++; $display("FAIL basic busy rise: got %b exp 1", b1); end
    checks++;
    if (d_at != W + 1) begin failures++; $display("FAIL basic done latency: got %0d exp %0d", d_at, W + 1); end
    checks++;
    if ({bo, df} !== {1'b0, 4'd6}) begin failures++; $display("FAIL basic 9-3: got %b_%h exp 0_6", bo, df); end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++; $display("FAIL basic done width: got done=%b busy=%b exp 0 0", Done, Busy);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{4'd3, 4'd0, 4'd15};
    logic [W-1:0] vb [3] = '{4'd9, 4'd0, 4'd15};
    logic         vc [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 23; i++) begin
      int d_at; logic b1; logic [W-1:0] df, a, b; logic bo, c; bit st;
      logic [W:0] exp;
      if (i < 3) begin a = va[i]; b = vb[i]; c = vc[i]; end
      else begin a = W'($urandom); b = W'($urandom); c = 1'($urandom); end
      exp = ref_sub(a, b, c);
      run_op(a, b, c, 0, d_at, b1, df, bo, st);
      checks++;
      if ({bo, df} !== exp || d_at != W + 1) begin
        failures++;
        $display("FAIL vec %0d-%0d-%0d: got %b_%h at %0d exp %b_%h at %0d", a, b, c, bo, df, d_at, exp[W], exp[W-1:0], W + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    int d_at, extra; logic b1; logic [W-1:0] df; logic bo; bit st;
    run_op(4'd9, 4'd3, 1'b0, 2, d_at, b1, df, bo, st);
    checks++;
    if ({bo, df} !== {1'b0, 4'd6} || d_at != W + 1) begin
      failures++; $display("FAIL ignore result: got %b_%h at %0d exp 0_6 at %0d", bo, df, d_at, W + 1);
    end
    extra = 0;
    repeat (W + 3) begin @(negedge Clk); if (Done) extra++; end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL ignore single done: got %0d extra pulses exp 0", extra); end
    run_op(4'd5, 4'd7, 1'b1, 0, d_at, b1, df, bo, st);
    checks++;
    if ({bo, df} !== ref_sub(4'd5, 4'd7, 1'b1)) begin
      failures++; $display("FAIL ignore next op: got %b_%h exp %b", bo, df, ref_sub(4'd5, 4'd7, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    int d_at, pulses; logic b1; logic [W-1:0] df; logic bo; bit st;
    @(negedge Clk);
    A = 4'd9; B = 4'd3; Bin = 1'b0; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk); Rst_n = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    checks++;
    if ({Busy, Done, Diff, Bout} !== '0) begin
      failures++;
      $display("FAIL midreset outputs: got busy=%b done=%b diff=%h bout=%b exp all 0", Busy, Done, Diff, Bout);
    end
    pulses = 0;
    repeat (W + 4) begin @(negedge Clk); if (Done) pulses++; end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL midreset no done: got %0d pulses exp 0", pulses); end
    run_op(4'd2, 4'd11, 1'b0, 0, d_at, b1, df, bo, st);
    checks++;
    if ({bo, df} !== ref_sub(4'd2, 4'd11, 1'b0) || d_at != W + 1) begin
      failures++; $display("FAIL midreset next op: got %b_%h at %0d exp %b", bo, df, d_at, ref_sub(4'd2, 4'd11, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 512; i++) begin
      int d_at; logic b1; logic [W-1:0] df, a, b; logic bo, c; bit st;
      logic [W:0] exp;
      a = W'(i >> 5); b = W'(i >> 1); c = 1'(i);
      exp = ref_sub(a, b, c);
      run_op(a, b, c, 0, d_at, b1, df, bo, st);
      checks++;
      if ({bo, df} !== exp || d_at != W + 1 || !st) begin
        failures++;
        $display("FAIL sweep %0d-%0d-%0d: got %b_%h at %0d stable=%0d exp %b_%h at %0d stable=1",
                 a, b, c, bo, df, d_at, st, exp[W], exp[W-1:0], W + 1);
      end
    end
  endtask

  initial begin
    test_full_sub();
    test_reset();
    test_basic();
    test_vectors();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing Diff = A - B - Bin, LSB first, one bit per clock.
- Built around a single full-subtractor cell plus a registered borrow, so it is the subtract-direction counterpart of the team's full adder.
- Used where area matters more than latency. Operands load on a Start pulse; the result is presented with a one-cycle Done pulse.

Parameters:
- WIDTH, 4, operand/result width in bits (WIDTH >= 1).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- Clk    input   1      single system clock; all state updates on rising edge.
- Rst_n  input   1      synchronous, active-low reset, sampled on rising Clk.
- Start  input   1      request; accepted only in IDLE.
- A      input   WIDTH  minuend, sampled on the accepted Start cycle.
- B      input   WIDTH  subtrahend, sampled on the accepted Start cycle.
- Bin    input   1      borrow-in, sampled on the accepted Start cycle.
- Busy   output  1      high while in SHIFT or DONE.
- Done   output  1      one-cycle pulse when result is valid.
- Diff   output  WIDTH  result, registered, held until next result.
- Bout   output  1      final borrow-out, registered, held with Diff.

Behaviour:
- Reset, with Rst_n low at a rising edge:
  - state = IDLE.
  - Busy = 0, Done = 0, Diff = 0, Bout = 0.
  - Internal shift registers, borrow register and counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Start = 1 → load a_sr <= A, b_sr <= B, br <= Bin, cnt <= 0, go to SHIFT.
  - Start = 0 → stay in IDLE.
- SHIFT, one bit per cycle:
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - d_sr <= {d, d_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; cnt <= cnt + 1.
  - On the cycle where cnt == WIDTH-1: also load Diff <= {d, d_sr[WIDTH-1:1]}, Bout <= next br, go to DONE.
- DONE: Done = 1 for exactly this cycle; go to IDLE unconditionally.
- Latency: Start accepted at edge k → WIDTH SHIFT cycles → Done high during the cycle after edge k+WIDTH, i.e. Start-to-Done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- Busy = (state != IDLE), decoded from registered state.
- Start while Busy (SHIFT or DONE) is ignored, not queued. A and B may change freely after acceptance.
- Diff/Bout change only on the final SHIFT edge; they remain stable through the following IDLE and the next operation's SHIFT cycles.
- Arithmetic: {Bout, Diff} == ({1'b0,A} - {1'b0,B} - Bin) mod 2^(WIDTH+1). Bout = 1 iff A < B + Bin (unsigned).
- WIDTH = 1: single SHIFT cycle, then DONE.
- Reset mid-operation (SHIFT or DONE): immediate return to IDLE with all outputs 0; no Done pulse for the aborted operation.
- Start asserted in the same cycle as Rst_n low: reset wins, Start is dropped.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum/localparams: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - the CNT_W derivation helper.
- Sub-module full_subtractor (combinational):
  - inputs A, B, Bin; outputs Diff, Bout;
  - one instance in the datapath;
  - unit-testable with the same 8-row exhaustive style as the full adder bench.

Test Plan:
- full_subtractor alone, all 8 {A,B,Bin} rows:
  - (0,0,0) → Diff 0, Bout 0;
  - (0,1,0) → 1,1;
  - (1,0,1) → 0,0;
  - (0,1,1) → 0,1.
- WIDTH=4, A=9, B=3, Bin=0, Start pulse:
  - Busy rises next edge;
  - Done high exactly 5 cycles after Start, for 1 cycle;
  - Diff=6, Bout=0.
- A=3, B=9, Bin=0 → Diff=4'hA, Bout=1. A=0, B=0, Bin=1 → Diff=4'hF, Bout=1. A=15, B=15, Bin=0 → Diff=0, Bout=0.
- Start re-asserted with A=1, B=1 during SHIFT of the 9-3 operation:
  - ignored; result still Diff=6;
  - a single Done pulse;
  - a new Start after Busy falls is accepted normally.
- Rst_n low for one cycle at the 3rd SHIFT cycle:
  - next edge Busy=0, Done=0, Diff=0, Bout=0;
  - no Done pulse follows;
  - the next operation computes correctly.
- Exhaustive sweep, all 512 {A,B,Bin} at WIDTH=4 back-to-back (Start as soon as Busy=0):
  - each result matches the reference model {Bout,Diff};
  - Diff stable between Done pulses.
